// File: rtl/fe_fifo_unpacker.sv
// Front-end FIFO unpacker: pops {cmd, time, data} entries and serialises each into
// a header byte plus optional timestamp and data bytes over a valid/ready byte stream.
//
// state | meaning
// IDLE  | waiting for a non-empty FIFO; read strobe issued from here
// FETCH | FIFO data valid this cycle, latched into the entry register
// HDR   | presenting header byte {cmd, short, ts_short, 2'b00}
// TSH   | presenting time[15:8]
// TSL   | presenting time[7:0]
// DATA  | presenting the data byte
module fe_fifo_unpacker #(
  parameter int pTIMESTAMP_FULL_WIDTH  = 16,
  parameter int pTIMESTAMP_SHORT_WIDTH = 3,
  parameter int pDATA_WIDTH            = 8,
  parameter int pCOUNT_WIDTH           = 24
) (
  input  logic                                              cwusb_clk,
  input  logic                                              reset_i,
  input  logic [2+pTIMESTAMP_FULL_WIDTH+pDATA_WIDTH-1:0]    I_fifo_dout,
  input  logic                                              I_fifo_empty,
  output logic                                              O_fifo_rd,
  input  logic                                              I_flush,
  input  logic                                              I_timestamps_disable,
  output logic [7:0]                                        O_byte,
  output logic                                              O_byte_valid,
  input  logic                                              I_byte_ready,
  output logic [pCOUNT_WIDTH-1:0]                           O_bytes_sent,
  output logic                                              O_idle
);

  localparam int TF = pTIMESTAMP_FULL_WIDTH;
  localparam int SW = pTIMESTAMP_SHORT_WIDTH;
  localparam int DW = pDATA_WIDTH;
  localparam int CW = pCOUNT_WIDTH;
  localparam int EW = 2 + TF + DW;
  localparam logic [1:0] FE_FIFO_CMD_TIME = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HDR, S_TSH, S_TSL, S_DATA} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic            tsdis_q, tsdis_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic            xfer, done, rd;

  function automatic logic is_short(input logic [EW-1:0] e, input logic tsdis);
    logic [TF-1:0] tm;
    tm = e[DW +: TF];
    return tsdis | ((tm >> SW) == '0);
  endfunction

  function automatic logic is_time(input logic [EW-1:0] e);
    return e[EW-1 -: 2] == FE_FIFO_CMD_TIME;
  endfunction

  function automatic logic [7:0] byte_for(input state_t st, input logic [EW-1:0] e,
                                          input logic tsdis);
    logic [TF-1:0] tm;
    logic [15:0]   tm16;
    logic          shrt;
    logic [2:0]    ts;
    tm   = e[DW +: TF];
    tm16 = 16'(tm);
    shrt = is_short(e, tsdis);
    ts   = (shrt & ~tsdis) ? 3'(tm[SW-1:0]) : 3'b000;
    case (st)
      S_HDR:   return {e[EW-1 -: 2], shrt, ts, 2'b00};
      S_TSH:   return tm16[15:8];
      S_TSL:   return tm16[7:0];
      S_DATA:  return 8'(e[DW-1:0]);
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    tsdis_d = tsdis_q;
    sent_d  = sent_q;
    done    = 1'b0;
    rd      = 1'b0;
    xfer    = valid_q & I_byte_ready;

    if (xfer && (sent_q != '1)) sent_d = sent_q + CW'(1);

    case (state_q)
      S_IDLE:  done = 1'b1;
      S_FETCH: begin
        entry_d = I_fifo_dout;
        tsdis_d = I_timestamps_disable;
        // a time entry with timestamps off carries nothing worth sending
        if (is_time(I_fifo_dout) && I_timestamps_disable) done = 1'b1;
        else                                              state_d = S_HDR;
      end
      S_HDR: if (xfer) begin
        if (!is_time(entry_q) && is_short(entry_q, tsdis_q)) state_d = S_DATA;
        else                                                 state_d = S_TSH;
      end
      S_TSH: if (xfer) state_d = S_TSL;
      S_TSL: if (xfer) begin
        if (is_time(entry_q)) done = 1'b1;
        else                  state_d = S_DATA;
      end
      S_DATA: if (xfer) done = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      state_d = S_IDLE;
      if (!I_fifo_empty && !I_flush && !reset_i) begin
        rd      = 1'b1;
        state_d = S_FETCH;
      end
    end

    if (I_flush) begin
      state_d = S_IDLE;
      entry_d = '0;
    end

    valid_d = (state_d == S_HDR) || (state_d == S_TSH) ||
              (state_d == S_TSL) || (state_d == S_DATA);
    byte_d  = valid_d ? byte_for(state_d, entry_d, tsdis_d) : 8'h00;
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      tsdis_q <= 1'b0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      tsdis_q <= tsdis_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      sent_q  <= sent_d;
    end
  end

  assign O_fifo_rd    = rd;
  assign O_byte       = byte_q;
  assign O_byte_valid = valid_q;
  assign O_bytes_sent = sent_q;
  assign O_idle       = (state_q == S_IDLE) & ~rd;

endmodule

// File: tb/tb_fe_fifo_unpacker.sv
// Scoreboard bench for fe_fifo_unpacker: a FIFO model feeds entries, expected bytes are
// queued at fetch time and a separate monitor compares every accepted byte.
module tb_fe_fifo_unpacker;
  localparam int TF = 16, SW = 3, DW = 8, CW = 6, EW = 2 + TF + DW;
  localparam int CMAX = (1 << CW) - 1;

  logic          cwusb_clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [EW-1:0] I_fifo_dout = '0;
  logic          I_fifo_empty = 1'b1;
  logic          O_fifo_rd;
  logic          I_flush = 1'b0;
  logic          I_timestamps_disable = 1'b0;
  logic [7:0]    O_byte;
  logic          O_byte_valid;
  logic          I_byte_ready = 1'b0;
  logic [CW-1:0] O_bytes_sent;
  logic          O_idle;

  fe_fifo_unpacker #(
    .pTIMESTAMP_FULL_WIDTH(TF), .pTIMESTAMP_SHORT_WIDTH(SW),
    .pDATA_WIDTH(DW), .pCOUNT_WIDTH(CW)
  ) dut (
    .cwusb_clk(cwusb_clk), .reset_i(reset_i), .I_fifo_dout(I_fifo_dout),
    .I_fifo_empty(I_fifo_empty), .O_fifo_rd(O_fifo_rd), .I_flush(I_flush),
    .I_timestamps_disable(I_timestamps_disable), .O_byte(O_byte),
    .O_byte_valid(O_byte_valid), .I_byte_ready(I_byte_ready),
    .O_bytes_sent(O_bytes_sent), .O_idle(O_idle)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  int checks = 0, errors = 0;
  logic [7:0]    exp_q[$];
  logic [EW-1:0] fifo_q[$];
  logic [EW-1:0] fetch_entry = '0;
  bit fetch_pending = 0;
  int n_xfer = 0, rd_cnt = 0;
  bit ready_force = 1, ready_val = 1, flush_req = 0, rst_req = 1, tsdis_val = 0, directed = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  function automatic logic [EW-1:0] mk(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
    return {c, t, d};
  endfunction

  // Reference: byte sequence an entry must produce, straight from the format rules.
  function automatic void model_push(input logic [EW-1:0] e, input bit tsdis);
    logic [1:0] cmd;
    logic [15:0] tm;
    logic [7:0] d;
    bit timed, shrt;
    logic [2:0] ts;
    cmd = e[EW-1:EW-2]; tm = e[DW +: 16]; d = e[7:0];
    timed = (cmd == 2'b10);
    shrt  = tsdis || (tm <= 16'd7);
    ts    = (shrt && !tsdis) ? tm[2:0] : 3'd0;
    if (timed && tsdis) return;
    exp_q.push_back({cmd, shrt, ts, 2'b00});
    if (timed || !shrt) begin
      exp_q.push_back(tm[15:8]);
      exp_q.push_back(tm[7:0]);
    end
    if (!timed) exp_q.push_back(d);
  endfunction

  function automatic logic [EW-1:0] rnd_entry();
    logic [15:0] t;
    case ($urandom_range(0, 3))
      0:       t = 16'($urandom_range(0, 7));
      1:       t = 16'($urandom_range(7, 8));
      default: t = 16'($urandom);
    endcase
    return mk(2'($urandom_range(0, 3)), t, 8'($urandom));
  endfunction

  task automatic step();
    @(negedge cwusb_clk);
    I_fifo_dout          = fetch_pending ? fetch_entry : EW'($urandom);
    reset_i              = rst_req;
    I_flush              = flush_req;
    I_timestamps_disable = tsdis_val;
    I_byte_ready         = (rst_req || flush_req) ? 1'b0 :
                           ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    I_fifo_empty         = (fifo_q.size() == 0);
    #1;
    if (fetch_pending && !I_flush && !reset_i && !directed)
      model_push(fetch_entry, I_timestamps_disable);
    fetch_pending = 0;
    if (I_flush || reset_i) exp_q.delete();
    if (reset_i) chk("rd_in_reset", O_fifo_rd, 0);
    if (O_fifo_rd) begin
      chk("rd_while_empty", I_fifo_empty, 0);
      chk("idle_during_rd", O_idle, 0);
      if (fifo_q.size() > 0) begin
        fetch_entry   = fifo_q.pop_front();
        fetch_pending = 1;
      end
      rd_cnt++;
    end
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    bit ok;
    k = 0;
    do begin
      step();
      k++;
      ok = (fifo_q.size() == 0) && !fetch_pending && (exp_q.size() == 0) && (O_idle === 1'b1);
    end while (!ok && k < 3000);
    chk({name, "_reach_idle"}, ok, 1);
  endtask

  task automatic wait_xfer(input int target, input string name);
    int k;
    k = 0;
    while (n_xfer < target && k < 100) begin
      step();
      k++;
    end
    chk({name, "_xfer_reached"}, n_xfer >= target, 1);
  endtask

  // Monitor: compares every accepted byte and checks hold-stability under backpressure.
  initial begin
    bit hold_v, flush_prev;
    logic [7:0] hold_b;
    hold_v = 0; flush_prev = 0; hold_b = 8'h00;
    forever begin
      @(negedge cwusb_clk);
      #1;
      if (reset_i) begin
        n_xfer = 0; hold_v = 0; flush_prev = 0;
      end else begin
        if (hold_v && !flush_prev) begin
          chk("hold_valid", O_byte_valid, 1);
          chk("hold_byte", O_byte, hold_b);
        end
        hold_v = 0;
        if (O_byte_valid && I_byte_ready) begin
          chk("bytes_sent", O_bytes_sent, sat(n_xfer));
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", O_byte);
          end else begin
            chk("byte", O_byte, exp_q.pop_front());
          end
          n_xfer++;
        end else if (O_byte_valid) begin
          hold_v = 1; hold_b = O_byte;
        end
        flush_prev = I_flush;
      end
    end
  end

  initial begin
    int rdc;
    // reset values
    rst_req = 1; step(); step();
    chk("rst_valid", O_byte_valid, 0);
    chk("rst_byte", O_byte, 0);
    chk("rst_sent", O_bytes_sent, 0);
    chk("rst_idle", O_idle, 1);
    chk("rst_rd", O_fifo_rd, 0);
    rst_req = 0; directed = 1; ready_force = 1; ready_val = 1;

    // short data entry
    rdc = rd_cnt;
    fifo_q.push_back(mk(2'd0, 16'd5, 8'hA5));
    exp_q.push_back(8'h34); exp_q.push_back(8'hA5);
    wait_idle("short_data");
    chk("short_data_rd_count", rd_cnt - rdc, 1);
    chk("short_data_sent", O_bytes_sent, 2);

    // long data entry
    fifo_q.push_back(mk(2'd1, 16'h1234, 8'h5A));
    exp_q.push_back(8'h40); exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h5A);
    wait_idle("long_data");
    chk("long_data_sent", O_bytes_sent, 6);

    // time entry, then the same with timestamps disabled
    fifo_q.push_back(mk(2'd2, 16'hFFFF, 8'h00));
    exp_q.push_back(8'h80); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    wait_idle("time_entry");
    chk("time_entry_sent", O_bytes_sent, 9);
    tsdis_val = 1; rdc = rd_cnt;
    fifo_q.push_back(mk(2'd2, 16'hFFFF, 8'h00));
    wait_idle("time_discard");
    chk("time_discard_rd_count", rd_cnt - rdc, 1);
    chk("time_discard_sent", O_bytes_sent, 9);
    tsdis_val = 0;

    // backpressure for 10 cycles in TSH with another entry waiting
    fifo_q.push_back(mk(2'd1, 16'h1234, 8'h5A));
    fifo_q.push_back(mk(2'd0, 16'd5, 8'hA5));
    exp_q.push_back(8'h40); exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h5A);
    exp_q.push_back(8'h34); exp_q.push_back(8'hA5);
    wait_xfer(10, "stall");
    ready_val = 0; rdc = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", O_byte_valid, 1);
      chk("stall_byte", O_byte, 8'h12);
      chk("stall_sent", O_bytes_sent, 10);
      chk("stall_rd_count", rd_cnt - rdc, 0);
    end
    ready_val = 1;
    wait_idle("stall");
    chk("stall_final_sent", O_bytes_sent, 15);

    // flush while in TSL
    fifo_q.push_back(mk(2'd1, 16'h1234, 8'h5A));
    fifo_q.push_back(mk(2'd0, 16'd3, 8'h11));
    exp_q.push_back(8'h40); exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h5A);
    wait_xfer(17, "flush");
    flush_req = 1; step();
    chk("flush_in_tsl_byte", O_byte, 8'h34);
    flush_req = 0;
    exp_q.push_back(8'h2C); exp_q.push_back(8'h11);
    step();
    chk("flush_valid_dropped", O_byte_valid, 0);
    wait_idle("flush");
    chk("flush_sent_kept", O_bytes_sent, 19);

    // reset mid-entry with the FIFO still holding data
    fifo_q.push_back(mk(2'd1, 16'h1234, 8'h5A));
    fifo_q.push_back(mk(2'd0, 16'd5, 8'hA5));
    exp_q.push_back(8'h40); exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h5A);
    wait_xfer(20, "midrst");
    rst_req = 1; step(); step();
    chk("midrst_valid", O_byte_valid, 0);
    chk("midrst_byte", O_byte, 0);
    chk("midrst_sent", O_bytes_sent, 0);
    chk("midrst_idle", O_idle, 1);
    chk("midrst_rd", O_fifo_rd, 0);
    rst_req = 0;
    exp_q.push_back(8'h34); exp_q.push_back(8'hA5);
    wait_idle("midrst");
    chk("midrst_after_sent", O_bytes_sent, 2);

    // counter saturation: reach all-ones minus 1, then push past it
    directed = 0; ready_force = 0;
    for (int i = 0; i < 30; i++)
      fifo_q.push_back(mk(2'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 8'($urandom)));
    wait_idle("sat_pre");
    chk("sat_pre_sent", O_bytes_sent, CMAX - 1);
    fifo_q.push_back(mk(2'd3, 16'($urandom_range(8, 65535)), 8'($urandom)));
    wait_idle("sat");
    chk("sat_sent", O_bytes_sent, CMAX);

    // random traffic with mid-entry timestamp-disable changes and occasional flushes
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) tsdis_val = ~tsdis_val;
      flush_req = ($urandom_range(0, 59) == 0);
      if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) fifo_q.push_back(rnd_entry());
      step();
    end
    flush_req = 0;
    wait_idle("random_drain");
    chk("random_drain_sent", O_bytes_sent, sat(n_xfer));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fe_fifo_unpacker.md
FE_FIFO_UNPACKER -- requirements
Module: fe_fifo_unpacker

Interface
REQ-001 SHALL have parameter pTIMESTAMP_FULL_WIDTH, default 16, full timestamp width of a FIFO entry.
REQ-002 SHALL have parameter pTIMESTAMP_SHORT_WIDTH, default 3, inline short-timestamp field width.
REQ-003 SHALL have parameter pDATA_WIDTH, default 8, front-end data width of a FIFO entry.
REQ-004 SHALL have parameter pCOUNT_WIDTH, default 24, sent-byte counter width.
REQ-005 SHALL have port cwusb_clk  input  1  sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port I_fifo_dout  input  2+pTIMESTAMP_FULL_WIDTH+pDATA_WIDTH  FE FIFO entry {command[1:0], time, data}.
REQ-008 SHALL have port I_fifo_empty  input  1  FE FIFO empty flag.
REQ-009 SHALL have port O_fifo_rd  output  1  FE FIFO read strobe; data valid on I_fifo_dout one cycle after the strobe.
REQ-010 SHALL have port I_flush  input  1  abandon the current entry and return to idle.
REQ-011 SHALL have port I_timestamps_disable  input  1  omit all timestamp bytes.
REQ-012 SHALL have port O_byte  output  8  output stream byte.
REQ-013 SHALL have port O_byte_valid  output  1  O_byte valid.
REQ-014 SHALL have port I_byte_ready  input  1  consumer accepts O_byte.
REQ-015 SHALL have port O_bytes_sent  output  pCOUNT_WIDTH  count of bytes accepted.
REQ-016 SHALL have port O_idle  output  1  high when in IDLE with no entry pending.

Function
REQ-017 Byte transfer SHALL occur on any cycle with O_byte_valid and I_byte_ready both high; while valid is high and ready is low, O_byte SHALL hold stable.
REQ-018 The FSM SHALL have states IDLE, FETCH, HDR, TSH, TSL, DATA.
REQ-019 IDLE: if I_fifo_empty=0 and I_flush=0, the block SHALL pulse O_fifo_rd for one cycle and go to FETCH; otherwise it SHALL stay in IDLE.
REQ-020 FETCH: the block SHALL latch I_fifo_dout into an entry register and go to HDR; this is one cycle and has no handshake.
REQ-021 Command code 2'b10 (FE_FIFO_CMD_TIME) SHALL denote a time entry; every other code SHALL denote a data entry.
REQ-022 The header byte SHALL be {cmd[1:0], short, ts_short[2:0], 2'b00}; short=1 iff I_timestamps_disable=1 or time <= 7; ts_short = time[2:0] when short and timestamps enabled, else 0.
REQ-023 A data entry with short=1 SHALL produce the sequence HDR, DATA (2 bytes).
REQ-024 A data entry with short=0 SHALL produce the sequence HDR, TSH (time[15:8]), TSL (time[7:0]), DATA (4 bytes).
REQ-025 A time entry SHALL produce HDR, TSH, TSL (3 bytes) when timestamps are enabled.
REQ-026 A time entry with I_timestamps_disable=1 SHALL be read from the FIFO and discarded with no bytes emitted.
REQ-027 Each state SHALL advance only on a transfer; after the last byte the FSM SHALL return to IDLE, or go directly to FETCH when a read can be issued the same cycle.
REQ-028 There SHALL be at most one outstanding O_fifo_rd; O_fifo_rd SHALL never assert when I_fifo_empty=1.
REQ-029 O_byte_valid SHALL be high exactly in HDR, TSH, TSL and DATA.
REQ-030 I_flush SHALL force IDLE on the next cycle from any state, drop O_byte_valid, and discard the entry; a read strobed in the same cycle SHALL have its data discarded.
REQ-031 I_flush SHALL NOT clear O_bytes_sent.
REQ-032 O_bytes_sent SHALL increment by 1 per transfer and saturate at all-ones without wrapping.
REQ-033 I_timestamps_disable SHALL be sampled once per entry in FETCH; changes mid-entry SHALL have no effect until the next entry.
REQ-034 O_idle SHALL equal (state==IDLE) & ~O_fifo_rd.

Reset
REQ-035 On reset_i the block SHALL set state=IDLE, O_fifo_rd=0, O_byte_valid=0, O_byte=0, O_bytes_sent=0, entry register=0 and O_idle=1.
REQ-036 Reset mid-entry SHALL discard the partial entry; no further bytes of that entry SHALL appear after reset.

Verification
REQ-037 The bench SHALL cover: data entry cmd=0, time=5, data=0xA5, ready held high -> bytes 0x34, 0xA5; one O_fifo_rd; O_bytes_sent=2.
REQ-038 The bench SHALL cover: data entry cmd=1, time=0x1234, data=0x5A -> bytes 0x40, 0x12, 0x34, 0x5A.
REQ-039 The bench SHALL cover: time entry time=0xFFFF -> bytes 0x80, 0xFF, 0xFF; the same entry with I_timestamps_disable=1 -> no bytes, FIFO still popped.
REQ-040 The bench SHALL cover: ready low for 10 cycles during TSH -> O_byte held at the same value, no count change, no extra O_fifo_rd.
REQ-041 The bench SHALL cover: I_flush asserted in TSL -> O_byte_valid=0 next cycle, state IDLE, next entry starts with a fresh header.
REQ-042 The bench SHALL cover: O_bytes_sent preloaded to all-ones minus 1, then 3 transfers -> counter stays at all-ones; reset mid-entry -> all outputs at reset values.
